// File: rtl/mx_int_bd_stream.sv
// -----------------------------------------------------------------------------
// mx_int_bd_stream
//
// Streaming FP32 -> MXINT block converter. BLOCK_SIZE binary32 elements are
// collected one per accepted beat, a shared E8M0 scale is taken from the
// largest effective exponent, then each element is quantised (one per cycle)
// to an ELEM_WIDTH-bit two's-complement integer in 1.(ELEM_WIDTH-2) fixed
// point with round-half-to-even and symmetric saturation. The finished block
// is presented on a single output beat.
//
// Handshake: a beat transfers on any rising edge where valid && ready are
// both high. The producer holds valid and data stable until that edge; ready
// and valid are decoded from registered state only, so neither side has a
// combinational path from the other's signal.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_in_valid   upstream element valid
//   i_float32    binary32 element
//   o_in_ready   converter is filling and can accept an element
//   o_out_valid  MX block valid
//   i_out_ready  downstream accepts the block
//   o_scale      shared scale; 8'hFF marks a NaN/Inf block
//   o_elements   element k at [k*ELEM_WIDTH +: ELEM_WIDTH]
//   o_sat        at least one element of the block saturated
// -----------------------------------------------------------------------------
module mx_int_bd_stream #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_in_valid,
    input  logic [31:0]                      i_float32,
    output logic                             o_in_ready,
    output logic                             o_out_valid,
    input  logic                             i_out_ready,
    output logic [7:0]                       o_scale,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_elements,
    output logic                             o_sat
);

    localparam int CW   = $clog2(BLOCK_SIZE);
    localparam int QMAX = (1 << (ELEM_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_CONVERT = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]                      buffer [BLOCK_SIZE];
    logic [CW-1:0]                    fill_cnt;
    logic [CW-1:0]                    conv_cnt;
    logic [7:0]                       max_exp;
    logic                             nan_q;
    logic                             sat_q;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] elements_q;

    logic in_fire;
    logic last_fill;
    logic last_conv;

    assign in_fire   = i_in_valid && (state == S_FILL);
    assign last_fill = (fill_cnt == CW'(BLOCK_SIZE - 1));
    assign last_conv = (conv_cnt == CW'(BLOCK_SIZE - 1));

    // Incoming element: effective exponent feeds the running block maximum.
    logic [7:0] in_exp;
    logic [7:0] in_eeff;
    assign in_exp  = i_float32[30:23];
    assign in_eeff = (in_exp == 8'd0) ? 8'd1 : in_exp;

    // Element under conversion.
    logic [31:0]           cv_word;
    logic [7:0]            cv_exp;
    logic [7:0]            cv_eeff;
    logic [23:0]           cv_sig;
    logic [8:0]            cv_shift;
    logic [48:0]           cv_ext;
    logic [23:0]           cv_q_raw;
    logic                  cv_guard;
    logic                  cv_sticky;
    logic [24:0]           cv_q_rnd;
    logic                  cv_sat;
    logic [ELEM_WIDTH-1:0] cv_mag;
    logic [ELEM_WIDTH-1:0] cv_elem;

    assign cv_word  = buffer[conv_cnt];
    assign cv_exp   = cv_word[30:23];
    assign cv_eeff  = (cv_exp == 8'd0) ? 8'd1 : cv_exp;
    assign cv_sig   = {cv_exp != 8'd0, cv_word[22:0]};
    // max_exp >= cv_eeff for every element of the block, so no underflow.
    assign cv_shift = {1'b0, max_exp - cv_eeff} + 9'(25 - ELEM_WIDTH);
    // Appending 25 zero bits keeps guard and sticky in view for any shift;
    // shifts beyond 25 drive both the integer part and the guard to zero.
    assign cv_ext    = {cv_sig, 25'd0} >> cv_shift;
    assign cv_q_raw  = cv_ext[48:25];
    assign cv_guard  = cv_ext[24];
    assign cv_sticky = |cv_ext[23:0];
    assign cv_q_rnd  = {1'b0, cv_q_raw} + {24'd0, cv_guard & (cv_sticky | cv_q_raw[0])};
    assign cv_sat    = (cv_q_rnd > 25'(QMAX));
    assign cv_mag    = cv_sat ? ELEM_WIDTH'(QMAX) : cv_q_rnd[ELEM_WIDTH-1:0];
    // Negative zero stays zero; the range is symmetric so -2^(W-1) never appears.
    assign cv_elem   = (cv_word[31] && (cv_mag != '0)) ? (-cv_mag) : cv_mag;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:    if (i_in_valid && last_fill) state_nxt = S_CONVERT;
            S_CONVERT: if (last_conv)               state_nxt = S_OUTPUT;
            S_OUTPUT:  if (i_out_ready)             state_nxt = S_FILL;
            default:                                state_nxt = S_FILL;
        endcase
    end

    // Element storage needs no reset: a discarded partial block is simply
    // overwritten by the next fill.
    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            buffer[fill_cnt] <= i_float32;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fill_cnt   <= '0;
            conv_cnt   <= '0;
            max_exp    <= 8'd0;
            nan_q      <= 1'b0;
            sat_q      <= 1'b0;
            elements_q <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_fire) begin
                        fill_cnt <= last_fill ? '0 : fill_cnt + 1'b1;
                        if (in_eeff > max_exp) max_exp <= in_eeff;
                        if (in_exp == 8'hFF)   nan_q   <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    elements_q[int'(conv_cnt)*ELEM_WIDTH +: ELEM_WIDTH] <=
                        nan_q ? '0 : cv_elem;
                    if (!nan_q && cv_sat) sat_q <= 1'b1;
                    conv_cnt <= last_conv ? '0 : conv_cnt + 1'b1;
                end
                S_OUTPUT: begin
                    // Block-level summaries restart once the block is taken.
                    if (i_out_ready) begin
                        max_exp <= 8'd0;
                        nan_q   <= 1'b0;
                        sat_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (state == S_FILL);
    assign o_out_valid = (state == S_OUTPUT);
    assign o_scale     = nan_q ? 8'hFF : max_exp;
    assign o_elements  = elements_q;
    assign o_sat       = sat_q;

endmodule

// File: tb/tb_mx_int_bd_stream.sv
// -----------------------------------------------------------------------------
// tb_mx_int_bd_stream
//
// Drives FP32 blocks into mx_int_bd_stream. Each complete block's expected
// scale/elements/sat come from a real-arithmetic reference and are queued;
// a negedge monitor pops and compares whenever a block is handed over, and
// also watches latency, hold-stability under backpressure and ready decode.
// -----------------------------------------------------------------------------
module tb_mx_int_bd_stream;

  localparam int BS   = 32;
  localparam int EW   = 8;
  localparam int QMAX = (1 << (EW - 1)) - 1;
  localparam int OW   = BS * EW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   float32 = 32'd0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    scale;
  logic [OW-1:0] elements;
  logic          sat;

  always #5 clk = ~clk;

  mx_int_bd_stream #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_float32   (float32),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_scale     (scale),
    .o_elements  (elements),
    .o_sat       (sat)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]    exp_scale_q[$];
  logic [OW-1:0] exp_elem_q[$];
  logic          exp_sat_q[$];
  int            n_vec  = 0;
  int            n_fail = 0;
  int            cycle  = 0;
  int            stall_req = 0;
  logic [31:0]   blk [BS];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Value of an element relative to the block scale, expressed in units of
  // 2^-(EW-2), then rounded to nearest-even and clamped symmetrically.
  task automatic model_push();
    int            x = 1;
    bit            nan = 1'b0;
    logic [OW-1:0] el = '0;
    bit            st = 1'b0;
    for (int i = 0; i < BS; i++) begin
      int e = int'(blk[i][30:23]);
      int ee = (e == 0) ? 1 : e;
      if (e == 255) nan = 1'b1;
      if (ee > x) x = ee;
    end
    if (!nan) begin
      for (int i = 0; i < BS; i++) begin
        int      e  = int'(blk[i][30:23]);
        int      ee = (e == 0) ? 1 : e;
        real     sig = real'(int'(blk[i][22:0]) + ((e != 0) ? (1 << 23) : 0));
        real     r  = sig * (2.0 ** real'(ee - x - 23 + EW - 2));
        real     fl = $floor(r);
        real     fr = r - fl;
        longint  q  = longint'($rtoi(fl));
        logic [EW-1:0] v;
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q = q + 1;
        if (q > QMAX) begin
          q  = QMAX;
          st = 1'b1;
        end
        if (blk[i][31] && q != 0) q = -q;
        v = q[EW-1:0];
        el[i*EW +: EW] = v;
      end
    end
    exp_scale_q.push_back(nan ? 8'hFF : 8'(x));
    exp_elem_q.push_back(el);
    exp_sat_q.push_back(nan ? 1'b0 : st);
  endtask

  // ---------------- drivers ----------------
  // Called with time just after a rising edge; returns in the same phase.
  task automatic send_elem(input logic [31:0] v);
    int guard = 0;
    in_valid = 1'b1;
    float32  = v;
    @(negedge clk);
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("accept_timeout", OW'(0), OW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if ($urandom_range(0, 5) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block();
    model_push();
    for (int i = 0; i < BS; i++) send_elem(blk[i]);
  endtask

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(118, 130));
    endcase
    if ($urandom_range(0, 399) == 0) e = 8'hFF;
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, OW'(out_valid), OW'(0));
    check({tag, "_scale"}, OW'(scale), OW'(0));
    check({tag, "_elems"}, elements, '0);
    check({tag, "_sat"},   OW'(sat), OW'(0));
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_scale_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (guard >= 2000) check("drain_timeout", OW'(exp_scale_q.size()), OW'(0));
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0 && out_valid) begin
        stall_req--;
        out_ready = 1'b0;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- monitor ----------------
  logic          prev_v = 1'b0;
  logic          fired_prev = 1'b0;
  int            last_acc = 0;
  logic [7:0]    cap_scale;
  logic [OW-1:0] cap_elem;
  logic          cap_sat;

  always @(negedge clk) begin
    if (rst) begin
      prev_v     = 1'b0;
      fired_prev = 1'b0;
    end else begin
      if (fired_prev) check("refill_ready", OW'(in_ready), OW'(1));
      if (out_valid) begin
        check("in_ready_low", OW'(in_ready), OW'(0));
        if (!prev_v) begin
          // CONVERT spans the BS cycles after the last accept; valid follows.
          check("latency", OW'(cycle - last_acc), OW'(BS));
        end else begin
          check("hold_scale", OW'(scale), OW'(cap_scale));
          check("hold_elems", elements, cap_elem);
          check("hold_sat",   OW'(sat), OW'(cap_sat));
        end
        cap_scale = scale;
        cap_elem  = elements;
        cap_sat   = sat;
        if (out_ready) begin
          if (exp_scale_q.size() == 0) begin
            check("unexpected_block", OW'(1), OW'(0));
          end else begin
            check("scale",    OW'(scale), OW'(exp_scale_q.pop_front()));
            check("elements", elements,   exp_elem_q.pop_front());
            check("sat",      OW'(sat),   OW'(exp_sat_q.pop_front()));
          end
        end
      end
      fired_prev = out_valid && out_ready;
      prev_v     = out_valid && !out_ready;
      if (in_valid && in_ready) last_acc = cycle + 1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check_reset_outputs("rst_in");
    check("rst_in_ready", OW'(in_ready), OW'(1));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic: all 1.0 -> scale 127, elements 0x40.
    for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000;
    send_block();

    // Mixed exponents.
    for (int i = 0; i < BS; i++) blk[i] = 32'h0;
    blk[0] = 32'h4000_0000;
    blk[1] = 32'h3F80_0000;
    blk[2] = 32'hBF00_0000;
    send_block();

    // Rounding and saturation against X = 127.
    for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000;
    blk[0] = 32'h3F81_0000;
    blk[1] = 32'h3F83_0000;
    blk[2] = 32'h3FFF_FFFF;
    blk[3] = 32'hBFFF_FFFF;
    blk[4] = 32'h8000_0000;
    send_block();

    // NaN block.
    for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000;
    blk[7] = 32'h7FC0_0000;
    send_block();

    // All zero / subnormal -> scale 1.
    for (int i = 0; i < BS; i++) blk[i] = (i % 2 == 0) ? 32'h0 : {1'b1, 8'd0, 23'($urandom)};
    send_block();

    // Backpressure: 10 stalled cycles while the next block is already offered.
    stall_req = 10;
    for (int i = 0; i < BS; i++) blk[i] = rand_float();
    send_block();
    for (int i = 0; i < BS; i++) blk[i] = rand_float();
    send_block();
    wait_drain();

    // Reset after 10 accepts of a partial block.
    for (int i = 0; i < 10; i++) send_elem(32'h4000_0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_fill");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-CONVERT of a full (unqueued) block.
    for (int i = 0; i < BS; i++) send_elem(32'h4100_0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_conv");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < BS; i++) blk[i] = 32'h3F80_0000;
    blk[5] = 32'hC040_0000;
    send_block();

    // Random blocks.
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < BS; i++) blk[i] = rand_float();
      send_block();
    end

    wait_drain();
    check("queue_empty", OW'(exp_scale_q.size()), OW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
